bash_f_ctrl: RTL and testbench
==============================

# bash_f_ctrl

Round sequencer for the bash-f permutation. Accepts a 1536-bit state on a start pulse and drives the registered single-round stage for 24 iterations, feeding the stage output back as the next round's input and generating the round constant for each round. It returns the permuted state with a one-cycle done pulse. Sits directly upstream of the round stage (owns its `data_i` and `c` inputs and consumes its `data_o`) and below the sponge/hash top level.

## Interface
- `ROUNDS`, default 24: number of stage iterations per permutation; legal range 1..31.
- `C_INIT`, default 64'h3BF5080AC8BA94B1: round-1 constant C1.
- `C_POLY`, default 64'hDC2BE1997FE0D8AE: constant-LFSR feedback word.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request; accepted only when `ready_o`=1.
- `state_i`  in  1536  input state; word w = bits [1535-64w -: 64], w=0..23; sampled on the accepting edge.
- `ready_o`  out  1  idle and able to accept `start_i`.
- `done_o`  out  1  one-cycle pulse; `state_o` is valid while high.
- `state_o`  out  1536  permuted state; holds until the next done.
- `stg_data_o`  out  1536  to stage `data_i`.
- `stg_c_o`  out  64  to stage `c`.
- `stg_data_i`  in  1536  from stage `data_o`; stage latency is exactly 1 cycle.

## Operation
- The FSM has three states: IDLE, RUN and FIN.
  - IDLE: `ready_o`=1. On `start_i`=1, `buf` <= `state_i`, `rnd` <= 1, go to RUN.
  - RUN: `rnd` runs 1..ROUNDS and increments each cycle. When `rnd`==ROUNDS, go to FIN.
  - FIN: `state_o` <= `stg_data_i`, `done_o` <= 1, go to IDLE.
- `done_o` is registered. It is high for exactly the cycle after the FIN edge, and is 0 at all other times.
- `stg_data_o` is combinational:
  - `buf` when in RUN with `rnd`==1;
  - `stg_data_i` otherwise. Its value is don't-care outside RUN but must be deterministic.
- `stg_c_o` is driven from register `creg`:
  - Reset value and value on entering IDLE: C_INIT.
  - In RUN, `creg` advances every cycle: `creg` <= (`creg` >> 1) ^ (`creg`[0] ? C_POLY : 0).
  - Round r therefore sees C_r: C1=64'h3BF5080AC8BA94B1, C2=64'hC1D1659C1BBD92F6.
- `start_i` while not in IDLE is ignored: it is not queued and has no effect on `buf` or `creg`.
- `state_i` is not sampled except on the accepting edge.
- Reset, asynchronous at any time including mid-RUN:
  - FSM to IDLE; `rnd`=0; `creg`=C_INIT; `buf`=0; `state_o`=0; `done_o`=0; `ready_o`=1.
  - The in-flight permutation is discarded. The stage register content is not this block's concern.
- `rnd` is 5 bits and never wraps within a run.

## Timing
- Let E0 be the edge that accepts `start_i`. Round r (1..ROUNDS) is driven between E(r-1) and E(r); the stage captures it at E(r).
- FIN occupies the cycle E(ROUNDS)..E(ROUNDS+1). `state_o` and `done_o` update at E(ROUNDS+1).
- Start-to-done latency is ROUNDS+1 edges (25 by default). `done_o` is high from E25 to E26.
- `ready_o` is 0 from E0 to E(ROUNDS+1) and 1 from E(ROUNDS+1) onward. It is combinational from the FSM state.
- Back-to-back:
  - A start presented in the `done_o`-high cycle is accepted at E26; `done_o` still falls at E26.
  - Throughput is one permutation per ROUNDS+1 cycles.
- There is no bubble between rounds. The stage output of round r feeds round r+1 in the same cycle it appears.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle with no clock -> immediately `ready_o`=1, `done_o`=0, `state_o`=0, `stg_c_o`=64'h3BF5080AC8BA94B1.
- **Constant sequence:** start with any state -> `stg_c_o` = 64'h3BF5080AC8BA94B1 in round 1 and 64'hC1D1659C1BBD92F6 in round 2. Rounds 3..24 must match the LFSR rule computed by the bench model.
- **Functional:** with the real stage attached, start with state words 64'hB194BAC80A08F53B ... (standard bash-f input vector) -> `done_o` rises exactly 25 edges after acceptance and `state_o` equals the software bash-f model output. Repeat with 100 random states.
- **Busy start:** `start_i` held high for cycles E1..E24 with a different `state_i` -> exactly one `done_o`, result of the first state only, `ready_o`=0 throughout.
- **Back-to-back:** second `start_i` in the `done_o` cycle -> accepted at E26, second `done_o` at E51. The first `state_o` holds from E25 to E51.
- **Mid-run reset:** `rst_n` low for 1 cycle at round 10, then start a new state -> no `done_o` for the aborted run, and the new result is correct 25 edges after its start.

Source files
------------

// File: rtl/bash_f_ctrl_if.sv
// Bus bundle between the bash-f round sequencer, its requester and its round stage.
interface bash_f_ctrl_if;
   logic           start_i;
   logic [1535:0]  state_i;
   logic           ready_o;
   logic           done_o;
   logic [1535:0]  state_o;
   logic [1535:0]  stg_data_o;
   logic [63:0]    stg_c_o;
   logic [1535:0]  stg_data_i;

   // Sequencer side.
   modport slave (
      input  start_i, state_i, stg_data_i,
      output ready_o, done_o, state_o, stg_data_o, stg_c_o
   );

   // Requester / stage side.
   modport master (
      output start_i, state_i, stg_data_i,
      input  ready_o, done_o, state_o, stg_data_o, stg_c_o
   );
endinterface

// File: rtl/bash_f_ctrl.sv
// bash-f round sequencer: loads a 1536-bit state, iterates the external
// one-cycle round stage ROUNDS times with an LFSR-generated round constant,
// and returns the result with a one-cycle done pulse.
module bash_f_ctrl #(
   parameter int          ROUNDS = 24,
   parameter logic [63:0] C_INIT = 64'h3BF5080AC8BA94B1,
   parameter logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE
) (
   input  logic        clk,
   input  logic        rst_n,
   bash_f_ctrl_if.slave bus
);

   localparam logic [4:0] RND_LAST = 5'(ROUNDS);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          fsm_reg;
   logic [4:0]      rnd_reg;
   logic [63:0]     creg_reg;
   logic [1535:0]   buf_reg;
   logic [1535:0]   state_reg;
   logic            done_reg;

   // Sequencer FSM with round counter, constant LFSR and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg   <= IDLE;
         rnd_reg   <= 5'd0;
         creg_reg  <= C_INIT;
         buf_reg   <= '0;
         state_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (fsm_reg)
            IDLE: begin
               creg_reg <= C_INIT;
               if (bus.start_i) begin
                  buf_reg <= bus.state_i;
                  rnd_reg <= 5'd1;
                  fsm_reg <= RUN;
               end
            end
            RUN: begin
               creg_reg <= (creg_reg >> 1) ^ (creg_reg[0] ? C_POLY : 64'd0);
               // The counter stops at the last round instead of wrapping,
               // so ROUNDS=31 never overflows the 5-bit field.
               if (rnd_reg == RND_LAST) begin
                  fsm_reg <= FIN;
               end else begin
                  rnd_reg <= rnd_reg + 5'd1;
               end
            end
            FIN: begin
               state_reg <= bus.stg_data_i;
               done_reg  <= 1'b1;
               rnd_reg   <= 5'd0;
               creg_reg  <= C_INIT;
               fsm_reg   <= IDLE;
            end
            default: begin
               fsm_reg <= IDLE;
            end
         endcase
      end
   end

   // Round 1 takes the loaded state; later rounds chain the stage output
   // straight back in, so there is no bubble between rounds.
   assign bus.stg_data_o = (fsm_reg == RUN && rnd_reg == 5'd1) ? buf_reg : bus.stg_data_i;
   assign bus.stg_c_o    = creg_reg;
   assign bus.ready_o    = (fsm_reg == IDLE);
   assign bus.done_o     = done_reg;
   assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_bash_f_ctrl.sv
// Self-checking bench for bash_f_ctrl with a registered stand-in round stage.
module tb_bash_f_ctrl;
   localparam int          ROUNDS = 24;
   localparam logic [63:0] C_INIT = 64'h3BF5080AC8BA94B1;
   localparam logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [63:0]   cexp [1:31];
   logic [1535:0] stg_q = '0;

   bash_f_ctrl_if bus ();

   bash_f_ctrl #(.ROUNDS(ROUNDS), .C_INIT(C_INIT), .C_POLY(C_POLY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stand-in round function: word mixing plus constant injection into word 0.
   function automatic logic [1535:0] mix(input logic [1535:0] x, input logic [63:0] c);
      logic [63:0]   a, b, d, e, y;
      logic [1535:0] r;
      r = '0;
      for (int w = 0; w < 24; w++) begin
         a = x[1535-64*w -: 64];
         b = x[1535-64*((w+1)%24) -: 64];
         d = x[1535-64*((w+5)%24) -: 64];
         e = x[1535-64*((w+7)%24) -: 64];
         y = a ^ ((b << (w+1)) | (b >> (63-w))) ^ (~d & e);
         if (w == 0) y = y ^ c;
         r[1535-64*w -: 64] = y;
      end
      return r;
   endfunction

   // Stage with exactly one cycle of latency.
   always @(posedge clk) stg_q <= mix(bus.stg_data_o, bus.stg_c_o);
   assign bus.stg_data_i = stg_q;

   // Reference permutation: ROUNDS applications with the constant table.
   function automatic logic [1535:0] perm(input logic [1535:0] s);
      logic [1535:0] t;
      t = s;
      for (int r = 1; r <= ROUNDS; r++) t = mix(t, cexp[r]);
      return t;
   endfunction

   function automatic logic [1535:0] rand_state();
      logic [1535:0] s;
      for (int i = 0; i < 48; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
      int fw;
      checks++;
      assert (obs === exp) else begin
         errors++;
         fw = 0;
         for (int w = 23; w >= 0; w--)
            if (obs[1535-64*w -: 64] !== exp[1535-64*w -: 64]) fw = w;
         $error("FAIL %s: word %0d observed %h required %h", tag, fw,
                obs[1535-64*fw -: 64], exp[1535-64*fw -: 64]);
      end
   endtask

   // One permutation from a negedge with the DUT idle; returns at the
   // negedge of the done cycle.
   task automatic run(input string tag, input logic [1535:0] s, input bit check_c,
                      input bit busy, input bit hold_en, input logic [1535:0] hold_val);
      int lat;
      chk({tag, "_ready_idle"}, {1535'd0, bus.ready_o}, 1536'd1);
      bus.start_i = 1'b1;
      bus.state_i = s;
      @(negedge clk);
      bus.start_i = busy;
      bus.state_i = busy ? ~s : rand_state();
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (bus.done_o === 1'b1) begin
            lat = k;
            break;
         end
         if (k < ROUNDS && check_c) chk($sformatf("%s_c%0d", tag, k+1), {1472'd0, bus.stg_c_o}, {1472'd0, cexp[k+1]});
         if (busy) chk($sformatf("%s_busy%0d", tag, k), {1535'd0, bus.ready_o}, 1536'd0);
         if (hold_en) chk($sformatf("%s_hold%0d", tag, k), bus.state_o, hold_val);
         if (busy && k == ROUNDS) bus.start_i = 1'b0;
         if (!busy) bus.state_i = rand_state();
         @(negedge clk);
      end
      bus.start_i = 1'b0;
      chk({tag, "_latency"}, 1536'(lat), 1536'(ROUNDS + 1));
      chk({tag, "_state"}, bus.state_o, perm(s));
      $display("txn %s: latency %0d result word0 %h", tag, lat, bus.state_o[1535 -: 64]);
   endtask

   initial begin
      logic [1535:0] s1, s2, v;
      int dn;
      bus.start_i = 1'b0;
      bus.state_i = '0;

      cexp[1] = 64'h3BF5080AC8BA94B1;
      cexp[2] = 64'hC1D1659C1BBD92F6;
      for (int r = 3; r <= 31; r++)
         cexp[r] = (cexp[r-1] >> 1) ^ (cexp[r-1][0] ? C_POLY : 64'd0);

      // Reset asserted between edges must take effect immediately.
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", {1535'd0, bus.ready_o}, 1536'd1);
      chk("rst_done", {1535'd0, bus.done_o}, 1536'd0);
      chk("rst_state", bus.state_o, 1536'd0);
      chk("rst_c", {1472'd0, bus.stg_c_o}, {1472'd0, 64'h3BF5080AC8BA94B1});
      $display("txn reset: ready %0b done %0b c %h", bus.ready_o, bus.done_o, bus.stg_c_o);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fixed vector with per-round constant checks.
      v[1535 -: 64] = 64'hB194BAC80A08F53B;
      for (int w = 1; w < 24; w++)
         v[1535-64*w -: 64] = {v[1535-64*(w-1) -: 64], v[1535-64*(w-1) -: 64]} >> 51 ^ 64'(w);
      run("vector", v, 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);

      // Random states.
      for (int i = 0; i < 100; i++) begin
         run($sformatf("rand%0d", i), rand_state(), (i < 3), 1'b0, 1'b0, '0);
         if (i % 2 == 0) @(negedge clk);
      end

      // Start held high while busy.
      s1 = rand_state();
      run("busy", s1, 1'b0, 1'b1, 1'b0, '0);
      dn = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) dn++;
      end
      chk("busy_extra_done", 1536'(dn), 1536'd0);
      chk("busy_state_held", bus.state_o, perm(s1));

      // Back-to-back: second start in the done cycle.
      s1 = rand_state();
      s2 = rand_state();
      run("b2b_first", s1, 1'b0, 1'b0, 1'b0, '0);
      run("b2b_second", s2, 1'b1, 1'b0, 1'b1, perm(s1));

      // Reset during round 10, then a fresh run.
      @(negedge clk);
      s1 = rand_state();
      bus.start_i = 1'b1;
      bus.state_i = s1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_c10", {1472'd0, bus.stg_c_o}, {1472'd0, cexp[10]});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {1535'd0, bus.ready_o}, 1536'd1);
      chk("mid_rst_state", bus.state_o, 1536'd0);
      chk("mid_rst_c", {1472'd0, bus.stg_c_o}, {1472'd0, C_INIT});
      $display("txn midreset: ready %0b c %h", bus.ready_o, bus.stg_c_o);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) dn++;
      end
      chk("mid_no_done", 1536'(dn), 1536'd0);
      s2 = rand_state();
      run("after_reset", s2, 1'b1, 1'b0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
